// File: rtl/axi_pkg.sv
// Shared AXI interconnect definitions: write-arbiter state
// encoding and the master ID nibbles prefixed onto slave-side IDs.
package axi_pkg;

    typedef enum logic [1:0] {
        WA_IDLE,
        WA_ADDR,
        WA_DATA,
        WA_RESP
    } wr_arb_state_t;

    localparam int AXI_MID_W = 4;

    localparam logic [AXI_MID_W-1:0] AXI_MASTER_0_ID = 4'h1;
    localparam logic [AXI_MID_W-1:0] AXI_MASTER_1_ID = 4'h2;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker.
// Ports: clk/rst; req[1:0] requests; last[1:0] one-hot owner to record;
//        update loads last into the pointer; gnt one-hot pick;
//        last_q registered last-granted pointer (resets to M1).
module rr_arb2
    import axi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] last,
    input  logic       update,
    output logic [1:0] gnt,
    output logic [1:0] last_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 2'b10;
        end else if (update) begin
            last_q <= last;
        end
    end

    // On a tie the master not granted last wins.
    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = last_q[0] ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-master AXI write scheduler: one whole write (AW, W burst, B)
// at a time, round-robin grant, master ID nibble prefixed on AWID_S.
// Ports: clk, rst (async, active-high); per-master AW/W/B channels
//        (_M0/_M1); slave-side AW/W/B channels (_S); grant_o one-hot
//        owner (00 when idle).
// Build option: WR_LEN_CHECK_EN adds W beat counting and the sticky
//        wlen_err_o burst-length error output.
module axi_wr_arbiter
    import axi_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_W-1:0]       AWID_M0,
    input  logic [ADDR_W-1:0]     AWADDR_M0,
    input  logic [LEN_W-1:0]      AWLEN_M0,
    input  logic [2:0]            AWSIZE_M0,
    input  logic [1:0]            AWBURST_M0,
    input  logic                  AWVALID_M0,
    output logic                  AWREADY_M0,
    input  logic [DATA_W-1:0]     WDATA_M0,
    input  logic [DATA_W/8-1:0]   WSTRB_M0,
    input  logic                  WLAST_M0,
    input  logic                  WVALID_M0,
    output logic                  WREADY_M0,
    output logic [ID_W-1:0]       BID_M0,
    output logic [1:0]            BRESP_M0,
    output logic                  BVALID_M0,
    input  logic                  BREADY_M0,
    input  logic [ID_W-1:0]       AWID_M1,
    input  logic [ADDR_W-1:0]     AWADDR_M1,
    input  logic [LEN_W-1:0]      AWLEN_M1,
    input  logic [2:0]            AWSIZE_M1,
    input  logic [1:0]            AWBURST_M1,
    input  logic                  AWVALID_M1,
    output logic                  AWREADY_M1,
    input  logic [DATA_W-1:0]     WDATA_M1,
    input  logic [DATA_W/8-1:0]   WSTRB_M1,
    input  logic                  WLAST_M1,
    input  logic                  WVALID_M1,
    output logic                  WREADY_M1,
    output logic [ID_W-1:0]       BID_M1,
    output logic [1:0]            BRESP_M1,
    output logic                  BVALID_M1,
    input  logic                  BREADY_M1,
    output logic [ID_W+3:0]       AWID_S,
    output logic [ADDR_W-1:0]     AWADDR_S,
    output logic [LEN_W-1:0]      AWLEN_S,
    output logic [2:0]            AWSIZE_S,
    output logic [1:0]            AWBURST_S,
    output logic                  AWVALID_S,
    input  logic                  AWREADY_S,
    output logic [DATA_W-1:0]     WDATA_S,
    output logic [DATA_W/8-1:0]   WSTRB_S,
    output logic                  WLAST_S,
    output logic                  WVALID_S,
    input  logic                  WREADY_S,
    input  logic [ID_W+3:0]       BID_S,
    input  logic [1:0]            BRESP_S,
    input  logic                  BVALID_S,
    output logic                  BREADY_S,
    output logic [1:0]            grant_o
`ifdef WR_LEN_CHECK_EN
    ,
    output logic                  wlen_err_o
`endif
);

    wr_arb_state_t state_q, state_d;
    logic [1:0]    own_q;
    logic          own1;
    logic [1:0]    req, gnt, last_q;
    logic          aw_hs, w_hs, b_hs;

    // Only one write is outstanding, so the returned ID nibble
    // carries no routing information.
    logic unused_bid_nib;
    assign unused_bid_nib = ^BID_S[ID_W+3:ID_W];

    assign req   = {AWVALID_M1, AWVALID_M0};
    assign own1  = own_q[1];
    assign aw_hs = AWVALID_S & AWREADY_S;
    assign w_hs  = WVALID_S & WREADY_S;
    assign b_hs  = BVALID_S & BREADY_S;

    rr_arb2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .last   (own_q),
        .update (b_hs),
        .gnt    (gnt),
        .last_q (last_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WA_IDLE;
            own_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            if (state_q == WA_IDLE && |req) begin
                own_q <= gnt;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WA_IDLE: if (|req) state_d = WA_ADDR;
            WA_ADDR: if (aw_hs) state_d = WA_DATA;
            WA_DATA: if (w_hs && WLAST_S) state_d = WA_RESP;
            WA_RESP: if (b_hs) state_d = WA_IDLE;
            default: state_d = WA_IDLE;
        endcase
    end

    always_comb begin
        AWID_S     = '0;
        AWADDR_S   = '0;
        AWLEN_S    = '0;
        AWSIZE_S   = '0;
        AWBURST_S  = '0;
        AWVALID_S  = 1'b0;
        WDATA_S    = '0;
        WSTRB_S    = '0;
        WLAST_S    = 1'b0;
        WVALID_S   = 1'b0;
        BREADY_S   = 1'b0;
        AWREADY_M0 = 1'b0;
        AWREADY_M1 = 1'b0;
        WREADY_M0  = 1'b0;
        WREADY_M1  = 1'b0;
        BID_M0     = '0;
        BRESP_M0   = '0;
        BVALID_M0  = 1'b0;
        BID_M1     = '0;
        BRESP_M1   = '0;
        BVALID_M1  = 1'b0;
        grant_o    = 2'b00;
        unique case (state_q)
            WA_ADDR: begin
                AWID_S = own1 ? {AXI_MASTER_1_ID, AWID_M1}
                              : {AXI_MASTER_0_ID, AWID_M0};
                AWADDR_S   = own1 ? AWADDR_M1  : AWADDR_M0;
                AWLEN_S    = own1 ? AWLEN_M1   : AWLEN_M0;
                AWSIZE_S   = own1 ? AWSIZE_M1  : AWSIZE_M0;
                AWBURST_S  = own1 ? AWBURST_M1 : AWBURST_M0;
                AWVALID_S  = own1 ? AWVALID_M1 : AWVALID_M0;
                AWREADY_M0 = ~own1 & AWREADY_S;
                AWREADY_M1 = own1 & AWREADY_S;
            end
            WA_DATA: begin
                WDATA_S   = own1 ? WDATA_M1  : WDATA_M0;
                WSTRB_S   = own1 ? WSTRB_M1  : WSTRB_M0;
                WLAST_S   = own1 ? WLAST_M1  : WLAST_M0;
                WVALID_S  = own1 ? WVALID_M1 : WVALID_M0;
                WREADY_M0 = ~own1 & WREADY_S;
                WREADY_M1 = own1 & WREADY_S;
            end
            WA_RESP: begin
                BREADY_S = own1 ? BREADY_M1 : BREADY_M0;
                if (own1) begin
                    BID_M1    = BID_S[ID_W-1:0];
                    BRESP_M1  = BRESP_S;
                    BVALID_M1 = BVALID_S;
                end else begin
                    BID_M0    = BID_S[ID_W-1:0];
                    BRESP_M0  = BRESP_S;
                    BVALID_M0 = BVALID_S;
                end
            end
            default: ;
        endcase
        if (state_q != WA_IDLE) begin
            grant_o = own_q;
        end
    end

`ifdef WR_LEN_CHECK_EN
    logic [LEN_W-1:0] len_q;
    logic [LEN_W:0]   beat_q;
    logic             err_q;

    // beat_q counts completed beats; the current beat is the last
    // legal one exactly when beat_q equals the latched AWLEN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q  <= '0;
            beat_q <= '0;
            err_q  <= 1'b0;
        end else if (aw_hs) begin
            len_q  <= AWLEN_S;
            beat_q <= '0;
        end else if (w_hs) begin
            beat_q <= beat_q + 1'b1;
            if (WLAST_S != (beat_q == {1'b0, len_q})) begin
                err_q <= 1'b1;
            end
        end
    end

    assign wlen_err_o = err_q;
`endif

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Self-checking bench for axi_wr_arbiter: directed and randomized
// write transactions checked against a transaction-level model.
module tb_axi_wr_arbiter;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 4;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [ID_W-1:0]     awid    [2];
    logic [ADDR_W-1:0]   awaddr  [2];
    logic [LEN_W-1:0]    awlen   [2];
    logic [2:0]          awsize  [2];
    logic [1:0]          awburst [2];
    logic [DATA_W-1:0]   wdata   [2];
    logic [DATA_W/8-1:0] wstrb   [2];
    logic [ID_W-1:0]     bid     [2];
    logic [1:0]          bresp   [2];
    logic [1:0] awvalid, awready, wlast, wvalid, wready;
    logic [1:0] bvalid, bready;

    logic [ID_W+3:0]     awid_s;
    logic [ADDR_W-1:0]   awaddr_s;
    logic [LEN_W-1:0]    awlen_s;
    logic [2:0]          awsize_s;
    logic [1:0]          awburst_s;
    logic                awvalid_s, awready_s;
    logic [DATA_W-1:0]   wdata_s;
    logic [DATA_W/8-1:0] wstrb_s;
    logic                wlast_s, wvalid_s, wready_s;
    logic [ID_W+3:0]     bid_s;
    logic [1:0]          bresp_s;
    logic                bvalid_s, bready_s;
    logic [1:0]          grant_o;
`ifdef WR_LEN_CHECK_EN
    logic                wlen_err_o;
`endif

    axi_wr_arbiter #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst),
        .AWID_M0(awid[0]), .AWADDR_M0(awaddr[0]), .AWLEN_M0(awlen[0]),
        .AWSIZE_M0(awsize[0]), .AWBURST_M0(awburst[0]),
        .AWVALID_M0(awvalid[0]), .AWREADY_M0(awready[0]),
        .WDATA_M0(wdata[0]), .WSTRB_M0(wstrb[0]), .WLAST_M0(wlast[0]),
        .WVALID_M0(wvalid[0]), .WREADY_M0(wready[0]),
        .BID_M0(bid[0]), .BRESP_M0(bresp[0]),
        .BVALID_M0(bvalid[0]), .BREADY_M0(bready[0]),
        .AWID_M1(awid[1]), .AWADDR_M1(awaddr[1]), .AWLEN_M1(awlen[1]),
        .AWSIZE_M1(awsize[1]), .AWBURST_M1(awburst[1]),
        .AWVALID_M1(awvalid[1]), .AWREADY_M1(awready[1]),
        .WDATA_M1(wdata[1]), .WSTRB_M1(wstrb[1]), .WLAST_M1(wlast[1]),
        .WVALID_M1(wvalid[1]), .WREADY_M1(wready[1]),
        .BID_M1(bid[1]), .BRESP_M1(bresp[1]),
        .BVALID_M1(bvalid[1]), .BREADY_M1(bready[1]),
        .AWID_S(awid_s), .AWADDR_S(awaddr_s), .AWLEN_S(awlen_s),
        .AWSIZE_S(awsize_s), .AWBURST_S(awburst_s),
        .AWVALID_S(awvalid_s), .AWREADY_S(awready_s),
        .WDATA_S(wdata_s), .WSTRB_S(wstrb_s), .WLAST_S(wlast_s),
        .WVALID_S(wvalid_s), .WREADY_S(wready_s),
        .BID_S(bid_s), .BRESP_S(bresp_s),
        .BVALID_S(bvalid_s), .BREADY_S(bready_s),
        .grant_o(grant_o)
`ifdef WR_LEN_CHECK_EN
        ,
        .wlen_err_o(wlen_err_o)
`endif
    );

    int tests = 0;
    int fails = 0;
    int last_m = 1;
    bit exp_err = 1'b0;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic raise(input int m, input int len);
        if (!awvalid[m]) begin
            awid[m]    = ID_W'($urandom);
            awaddr[m]  = ADDR_W'($urandom);
            awlen[m]   = LEN_W'(len);
            awsize[m]  = 3'($urandom);
            awburst[m] = 2'($urandom);
            awvalid[m] = 1'b1;
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_grant"}, 64'(grant_o), 64'(0));
        chk({tag, "_awv_s"}, 64'(awvalid_s), 64'(0));
        chk({tag, "_aw_s"}, 64'({awid_s, awaddr_s, awlen_s}), 64'(0));
        chk({tag, "_wv_s"}, 64'({wvalid_s, wdata_s, wlast_s}), 64'(0));
        chk({tag, "_br_s"}, 64'(bready_s), 64'(0));
        chk({tag, "_rdy_m"}, 64'({awready, wready}), 64'(0));
        chk({tag, "_bv_m"}, 64'(bvalid), 64'(0));
    endtask

    // One whole write. The winner comes from the round-robin rule:
    // with both requesting, the master not granted last wins.
    task automatic run_txn(input bit r0, input bit r1, input int len,
                           input int awdly, input int wmode,
                           input int bdly, input bit raise_mid,
                           input int early, input int rst_beat);
        int w, o, nb, b, cyc;
        logic [1:0] g;
        logic [ID_W+3:0] bids;
        logic [1:0] bresps;
        @(negedge clk);
        awready_s = 1'b0; wready_s = 1'b0; bvalid_s = 1'b0;
        bready = '0; wvalid = '0; wlast = '0;
        if (r0) raise(0, len);
        if (r1) raise(1, len);
        if (awvalid == 2'b00) raise(0, len);
        w = (awvalid == 2'b11) ? 1 - last_m : (awvalid[0] ? 0 : 1);
        o = 1 - w;
        g = (w == 1) ? 2'b10 : 2'b01;
        #1;
        chk("idle_grant", 64'(grant_o), 64'(0));
        chk("idle_awv_s", 64'(awvalid_s), 64'(0));
        chk("idle_awrdy", 64'(awready), 64'(0));
        for (int d = 0; d <= awdly; d++) begin
            @(negedge clk);
            awready_s = (d == awdly);
            #1;
            chk("aw_grant", 64'(grant_o), 64'(g));
            chk("aw_valid_s", 64'(awvalid_s), 64'(1));
            chk("aw_fields",
                64'({awid_s, awaddr_s, awlen_s, awsize_s, awburst_s}),
                64'({(w == 1) ? 4'h2 : 4'h1, awid[w], awaddr[w],
                     awlen[w], awsize[w], awburst[w]}));
            chk("aw_rdy_own", 64'(awready[w]), 64'(awready_s));
            chk("aw_rdy_oth", 64'(awready[o]), 64'(0));
            chk("aw_wv_s", 64'(wvalid_s), 64'(0));
        end
        nb = (early >= 0) ? early + 1 : int'(awlen[w]) + 1;
        b = 0;
        cyc = 0;
        wdata[w] = DATA_W'($urandom);
        wstrb[w] = (DATA_W/8)'($urandom);
        while (b < nb) begin
            @(negedge clk);
            awvalid[w] = 1'b0;
            awready_s = 1'b0;
            if (cyc == 0 && raise_mid) raise(0, len);
            wvalid[w] = 1'b1;
            wlast[w] = (b == nb - 1);
            wvalid[o] = 1'b1;
            wdata[o] = DATA_W'($urandom);
            wlast[o] = 1'($urandom);
            case (wmode)
                0: wready_s = 1'b1;
                1: wready_s = (cyc % 2) == 1;
                default: wready_s = 1'($urandom_range(0, 1));
            endcase
            if (b == rst_beat) begin
                rst = 1'b1;
                #1;
                chk_quiet("rst");
                @(negedge clk);
                rst = 1'b0;
                awvalid = '0; wvalid = '0; wlast = '0;
                wready_s = 1'b0;
                last_m = 1;
                exp_err = 1'b0;
                return;
            end
            #1;
            chk("w_grant", 64'(grant_o), 64'(g));
            chk("w_valid_s", 64'(wvalid_s), 64'(1));
            chk("w_fields", 64'({wdata_s, wstrb_s, wlast_s}),
                64'({wdata[w], wstrb[w], wlast[w]}));
            chk("w_rdy_own", 64'(wready[w]), 64'(wready_s));
            chk("w_rdy_oth", 64'({wready[o], awready[o]}), 64'(0));
            chk("w_awv_s", 64'(awvalid_s), 64'(0));
            if (wready_s) begin
                b++;
                wdata[w] = DATA_W'($urandom);
                wstrb[w] = (DATA_W/8)'($urandom);
            end
            cyc++;
        end
        if (nb != int'(awlen[w]) + 1) exp_err = 1'b1;
        bids = (ID_W+4)'($urandom);
        bresps = 2'($urandom);
        for (int d = 0; d <= bdly; d++) begin
            @(negedge clk);
            wvalid = '0; wlast = '0; wready_s = 1'b0;
            bvalid_s = 1'b1;
            bid_s = bids;
            bresp_s = bresps;
            bready[w] = (d == bdly);
            bready[o] = (d != bdly);
            #1;
            chk("b_grant", 64'(grant_o), 64'(g));
            chk("b_valid_own", 64'(bvalid[w]), 64'(1));
            chk("b_valid_oth", 64'(bvalid[o]), 64'(0));
            chk("b_fields_own", 64'({bid[w], bresp[w]}),
                64'({bids[ID_W-1:0], bresps}));
            chk("b_fields_oth", 64'({bid[o], bresp[o]}), 64'(0));
            chk("b_ready_s", 64'(bready_s), 64'(bready[w]));
            chk("b_wv_s", 64'({wvalid_s, awvalid_s, awready[o]}), 64'(0));
`ifdef WR_LEN_CHECK_EN
            chk("wlen_err", 64'(wlen_err_o), 64'(exp_err));
`endif
        end
        last_m = w;
    endtask

    initial begin
        awvalid = '0; wvalid = '0; wlast = '0; bready = '0;
        awready_s = 1'b0; wready_s = 1'b0; bvalid_s = 1'b0;
        bid_s = '0; bresp_s = '0;
        for (int i = 0; i < 2; i++) begin
            awid[i] = '0; awaddr[i] = '0; awlen[i] = '0;
            awsize[i] = '0; awburst[i] = '0;
            wdata[i] = '0; wstrb[i] = '0;
        end
        repeat (2) @(negedge clk);
        awvalid = 2'b11;
        #1;
        chk_quiet("reset");
        awvalid = 2'b00;
        rst = 1'b0;

        // single M0 write, AWLEN=3, slave always ready
        run_txn(1, 0, 3, 0, 0, 0, 0, -1, -1);
        // simultaneous requests, four transactions
        repeat (4) run_txn(1, 1, 1, 0, 0, 0, 0, -1, -1);
        // M1 owns while M0 raises during DATA, then M0 drains
        run_txn(0, 1, 2, 0, 0, 0, 1, -1, -1);
        run_txn(0, 0, 2, 0, 0, 0, 0, -1, -1);
        // stalls in every phase
        run_txn(1, 0, 3, 3, 1, 2, 0, -1, -1);
        // reset mid-burst, then both request: M0 must win
        run_txn(0, 1, 3, 0, 0, 0, 0, -1, 2);
        run_txn(1, 1, 2, 0, 0, 0, 0, -1, -1);
        run_txn(0, 0, 1, 1, 2, 1, 0, -1, -1);
`ifdef WR_LEN_CHECK_EN
        run_txn(1, 0, 3, 0, 0, 0, 0, 1, -1);
        run_txn(1, 0, 3, 0, 0, 0, 0, -1, -1);
`endif
        for (int k = 0; k < 12; k++) begin
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                    2, int'($urandom_range(0, 3)), 0, -1, -1);
        end
        while (awvalid != 2'b00) begin
            run_txn(0, 0, 0, 0, 0, 0, 0, -1, -1);
        end
        repeat (2) @(negedge clk);
        bvalid_s = 1'b0; bready = '0;
        #1;
        chk("end_grant", 64'(grant_o), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
